// File: rtl/reset_boot_sequencer_if.sv
// Controller-side bundle of the boot sequencer: software reset request in,
// per-domain resets and sequence status out.
interface reset_boot_sequencer_if #(
  parameter int NUM_OUTPUTS = 4
);
  logic                   sw_reset_req;
  logic [NUM_OUTPUTS-1:0] sw_reset_mask;
  logic [NUM_OUTPUTS-1:0] reset_o;
  logic                   all_released;
  logic                   busy;
  logic [7:0]             seq_count;

  modport master (
    output sw_reset_req,
    output sw_reset_mask,
    input  reset_o,
    input  all_released,
    input  busy,
    input  seq_count
  );

  modport slave (
    input  sw_reset_req,
    input  sw_reset_mask,
    output reset_o,
    output all_released,
    output busy,
    output seq_count
  );
endinterface

// File: rtl/reset_boot_sequencer.sv
// Staggered multi-domain reset release after power-on and on software request.
// reset_o is flopped; requests outside RUN are dropped, never queued.
module reset_boot_sequencer #(
  parameter int NUM_OUTPUTS    = 4,
  parameter int POR_CYCLES     = 20,
  parameter int STAGGER_CYCLES = 4,
  parameter int SW_PULSE_MIN   = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  reset_boot_sequencer_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0]   POR_C   = CNT_WIDTH'(POR_CYCLES);
  localparam logic [CNT_WIDTH-1:0]   STG_C   = CNT_WIDTH'(STAGGER_CYCLES);
  localparam logic [CNT_WIDTH-1:0]   PULSE_C = CNT_WIDTH'(SW_PULSE_MIN);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE = CNT_WIDTH'(1);
  localparam logic [NUM_OUTPUTS-1:0] ONE_N   = NUM_OUTPUTS'(1);

  typedef enum logic [2:0] {
    ST_POR_HOLD,
    ST_RELEASE,
    ST_RUN,
    ST_SW_HOLD,
    ST_SW_RELEASE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_OUTPUTS-1:0] pend_q, pend_d;
  logic [NUM_OUTPUTS-1:0] rst_q, rst_d;
  logic [7:0]             seq_q = 8'd0;
  logic [7:0]             seq_d;

  logic                   step;
  state_e                 rel_state;
  logic [NUM_OUTPUTS-1:0] lsb;
  logic [NUM_OUTPUTS-1:0] drop;
  logic [NUM_OUTPUTS-1:0] pend_left;

  // pend_q tracks domains still held by the running sequence; they drop
  // lowest index first, or all together when there is no stagger.
  assign lsb       = pend_q & (~pend_q + ONE_N);
  assign drop      = (STAGGER_CYCLES == 0) ? pend_q : lsb;
  assign pend_left = pend_q & ~drop;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    pend_d    = pend_q;
    rst_d     = rst_q;
    seq_d     = seq_q;
    step      = 1'b0;
    rel_state = ST_RELEASE;

    case (state_q)
      ST_POR_HOLD: begin
        step      = (cnt_q == POR_C);
        rel_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        step      = (cnt_q == STG_C);
        rel_state = ST_RELEASE;
      end
      ST_RUN: begin
        cnt_d = '0;
        if (bus.sw_reset_req && (bus.sw_reset_mask != '0)) begin
          rst_d   = rst_q | bus.sw_reset_mask;
          pend_d  = bus.sw_reset_mask;
          cnt_d   = CNT_ONE;
          state_d = ST_SW_HOLD;
        end
      end
      ST_SW_HOLD: begin
        step      = (cnt_q == PULSE_C);
        rel_state = ST_SW_RELEASE;
      end
      ST_SW_RELEASE: begin
        step      = (cnt_q == STG_C);
        rel_state = ST_SW_RELEASE;
      end
      default: begin
        state_d = ST_POR_HOLD;
        cnt_d   = '0;
        pend_d  = '1;
        rst_d   = '1;
      end
    endcase

    if (step) begin
      rst_d  = rst_q & ~drop;
      pend_d = pend_left;
      cnt_d  = CNT_ONE;
      if (pend_left == '0) begin
        state_d = ST_RUN;
        cnt_d   = '0;
        seq_d   = (seq_q == 8'hFF) ? seq_q : seq_q + 8'd1;
      end else begin
        state_d = rel_state;
      end
    end
  end

  // The sequence counter survives reset on purpose: it counts boots.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_POR_HOLD;
      cnt_q   <= '0;
      pend_q  <= '1;
      rst_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rst_q   <= rst_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.reset_o      = rst_q;
  assign bus.busy         = (state_q != ST_RUN);
  assign bus.all_released = (state_q == ST_RUN) && (rst_q == '0);
  assign bus.seq_count    = seq_q;

endmodule

// File: tb/tb_reset_boot_sequencer.sv
// Directed bench for reset_boot_sequencer: default build plus a no-stagger build.
module tb_reset_boot_sequencer;

  logic clk;
  logic reset;
  logic reset2;
  int   passed;
  int   total;

  reset_boot_sequencer_if #(.NUM_OUTPUTS(4)) ifa ();
  reset_boot_sequencer_if #(.NUM_OUTPUTS(4)) ifb ();

  reset_boot_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  reset_boot_sequencer #(
    .NUM_OUTPUTS    (4),
    .POR_CYCLES     (5),
    .STAGGER_CYCLES (0),
    .SW_PULSE_MIN   (8),
    .CNT_WIDTH      (16)
  ) dut_ns (
    .clk   (clk),
    .reset (reset2),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input int n, input logic [7:0] seq_exp);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      total++;
      if (ifa.reset_o !== 4'hF) $display("FAIL rst_reset_o got=%h exp=f", ifa.reset_o);
      else passed++;
      total++;
      if (ifa.busy !== 1'b1 || ifa.all_released !== 1'b0)
        $display("FAIL rst_status busy=%b all_rel=%b exp busy=1 all_rel=0", ifa.busy, ifa.all_released);
      else passed++;
      total++;
      if (ifa.seq_count !== seq_exp) $display("FAIL rst_seq got=%0d exp=%0d", ifa.seq_count, seq_exp);
      else passed++;
    end
    reset = 1'b0;
  endtask

  task automatic test_power_on(input bit inject, input logic [7:0] seq_before);
    int         cyc[8] = '{0, 19, 20, 23, 24, 28, 31, 32};
    logic [3:0] val[8] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hC, 4'h8, 4'h8, 4'h0};
    for (int k = 0; k <= 32; k++) begin
      tick();
      ifa.sw_reset_req  = (inject && k == 10);
      ifa.sw_reset_mask = (inject && k == 10) ? 4'hF : 4'h0;
      for (int i = 0; i < 8; i++) begin
        if (cyc[i] == k) begin
          total++;
          if (ifa.reset_o !== val[i]) $display("FAIL por_reset_o cycle=%0d got=%h exp=%h", k, ifa.reset_o, val[i]);
          else passed++;
        end
      end
      if (k == 31) begin
        total++;
        if (ifa.busy !== 1'b1 || ifa.all_released !== 1'b0 || ifa.seq_count !== seq_before)
          $display("FAIL por_pre_done busy=%b all_rel=%b seq=%0d exp 1 0 %0d", ifa.busy, ifa.all_released, ifa.seq_count, seq_before);
        else passed++;
      end
      if (k == 32) begin
        total++;
        if (ifa.busy !== 1'b0 || ifa.all_released !== 1'b1 || ifa.seq_count !== seq_before + 8'd1)
          $display("FAIL por_done busy=%b all_rel=%b seq=%0d exp 0 1 %0d", ifa.busy, ifa.all_released, ifa.seq_count, seq_before + 8'd1);
        else passed++;
      end
    end
  endtask

  task automatic test_sw_reset(input bit inject, input logic [7:0] seq_before);
    logic [3:0] exp;
    tick();
    tick();
    ifa.sw_reset_req  = 1'b1;
    ifa.sw_reset_mask = 4'b1010;
    for (int j = 1; j <= 13; j++) begin
      tick();
      ifa.sw_reset_req  = (inject && j == 3);
      ifa.sw_reset_mask = (inject && j == 3) ? 4'b0001 : 4'b0000;
      exp = (j <= 8) ? 4'b1010 : (j <= 12) ? 4'b1000 : 4'b0000;
      total++;
      if (ifa.reset_o !== exp) $display("FAIL sw_reset_o step=%0d got=%b exp=%b", j, ifa.reset_o, exp);
      else passed++;
      if (j == 1 || j == 12) begin
        total++;
        if (ifa.busy !== 1'b1 || ifa.all_released !== 1'b0)
          $display("FAIL sw_busy step=%0d busy=%b all_rel=%b exp 1 0", j, ifa.busy, ifa.all_released);
        else passed++;
      end
    end
    total++;
    if (ifa.busy !== 1'b0 || ifa.all_released !== 1'b1 || ifa.seq_count !== seq_before + 8'd1)
      $display("FAIL sw_done busy=%b all_rel=%b seq=%0d exp 0 1 %0d", ifa.busy, ifa.all_released, ifa.seq_count, seq_before + 8'd1);
    else passed++;
    for (int j = 0; j < 4; j++) tick();
    total++;
    if (ifa.reset_o !== 4'h0 || ifa.seq_count !== seq_before + 8'd1)
      $display("FAIL sw_settled reset_o=%b seq=%0d exp 0000 %0d", ifa.reset_o, ifa.seq_count, seq_before + 8'd1);
    else passed++;
  endtask

  task automatic test_ignored_req(input logic [7:0] seq_now);
    ifa.sw_reset_req  = 1'b1;
    ifa.sw_reset_mask = 4'h0;
    tick();
    ifa.sw_reset_req  = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      total++;
      if (ifa.reset_o !== 4'h0 || ifa.busy !== 1'b0 || ifa.all_released !== 1'b1 || ifa.seq_count !== seq_now)
        $display("FAIL zero_mask reset_o=%b busy=%b all_rel=%b seq=%0d exp 0000 0 1 %0d",
                 ifa.reset_o, ifa.busy, ifa.all_released, ifa.seq_count, seq_now);
      else passed++;
    end
    test_reset(3, seq_now);
    test_power_on(1'b1, seq_now);
  endtask

  task automatic test_reset_midseq(input logic [7:0] seq_now);
    test_reset(3, seq_now);
    for (int k = 0; k <= 26; k++) tick();
    total++;
    if (ifa.reset_o !== 4'hC || ifa.seq_count !== seq_now)
      $display("FAIL mid_before reset_o=%h seq=%0d exp c %0d", ifa.reset_o, ifa.seq_count, seq_now);
    else passed++;
    test_reset(1, seq_now);
    test_power_on(1'b0, seq_now);
  endtask

  task automatic test_no_stagger();
    reset2 = 1'b1;
    tick();
    total++;
    if (ifb.reset_o !== 4'hF || ifb.seq_count !== 8'd0)
      $display("FAIL ns_reset reset_o=%h seq=%0d exp f 0", ifb.reset_o, ifb.seq_count);
    else passed++;
    reset2 = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        total++;
        if (ifb.reset_o !== 4'hF || ifb.all_released !== 1'b0)
          $display("FAIL ns_hold reset_o=%h all_rel=%b exp f 0", ifb.reset_o, ifb.all_released);
        else passed++;
      end
      if (k == 5) begin
        total++;
        if (ifb.reset_o !== 4'h0 || ifb.all_released !== 1'b1 || ifb.busy !== 1'b0 || ifb.seq_count !== 8'd1)
          $display("FAIL ns_release reset_o=%h all_rel=%b busy=%b seq=%0d exp 0 1 0 1",
                   ifb.reset_o, ifb.all_released, ifb.busy, ifb.seq_count);
        else passed++;
      end
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    reset2 = 1'b1;
    ifa.sw_reset_req  = 1'b0;
    ifa.sw_reset_mask = 4'h0;
    ifb.sw_reset_req  = 1'b0;
    ifb.sw_reset_mask = 4'h0;

    test_reset(3, 8'd0);
    test_power_on(1'b0, 8'd0);
    test_sw_reset(1'b0, 8'd1);
    test_sw_reset(1'b1, 8'd2);
    test_ignored_req(8'd3);
    test_reset_midseq(8'd4);
    test_no_stagger();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reset_boot_sequencer.md
Name: reset_boot_sequencer

Overview:
Multi-domain successor to the single-output boot reset generator. It holds N reset outputs asserted after power-up or board reset, then releases them one by one in a staggered order. Typical domains are the controller, the core, and the memories. The controller can also request a software reset of any subset of domains; that subset is re-asserted and released with the same staggering.

Parameters:
NUM_OUTPUTS, 4, number of reset domains (1..16); index 0 is released first.
POR_CYCLES, 20, cycles all outputs stay asserted after reset deasserts (>=1).
STAGGER_CYCLES, 4, cycles between consecutive domain releases (0 = release all at once).
SW_PULSE_MIN, 8, cycles masked domains stay asserted after a software request (>=1).
CNT_WIDTH, 16, width of the internal cycle counter; it must hold max(POR_CYCLES, SW_PULSE_MIN, STAGGER_CYCLES).

Ports:
clk  in  1  single clock; all logic on posedge.
reset  in  1  synchronous, active-high; restarts the full power-on sequence.
sw_reset_req  in  1  single-cycle software reset request from the controller.
sw_reset_mask  in  NUM_OUTPUTS  domains to reset; sampled only on an accepted request.
reset_o  out  NUM_OUTPUTS  per-domain reset, active-high, registered.
all_released  out  1  high when reset_o is all zeros and the FSM is in RUN.
busy  out  1  high in every state except RUN.
seq_count  out  8  completed sequences (power-on plus software); saturates at 255.

Behaviour:
- Reset (reset=1 at an edge):
  - reset_o = all ones, all_released = 0, busy = 1.
  - FSM enters POR_HOLD and the counter clears.
  - seq_count is not cleared; it is zero only from the initial block value.
  - reset has priority over every other input in every state, including mid-sequence.
- Cycle numbering: cycle 0 is the first cycle in which reset is sampled low.
- POR_HOLD: counter runs for POR_CYCLES cycles; reset_o[0] is first low in cycle POR_CYCLES.
- RELEASE: reset_o[i] is first low in cycle POR_CYCLES + i*STAGGER_CYCLES.
  - If STAGGER_CYCLES=0, all bits drop in cycle POR_CYCLES.
- Completion: in the cycle the last bit drops:
  - FSM enters RUN; busy = 0; all_released = 1.
  - seq_count increments by 1 (saturating).
- RUN, request accepted: sw_reset_req=1 with a nonzero mask.
  - Mask is latched; next cycle, reset_o |= mask; busy = 1; all_released = 0.
  - Unmasked domains stay deasserted and are never glitched.
- RUN, request ignored: sw_reset_req=1 with mask = 0.
- SW_HOLD: masked bits stay asserted SW_PULSE_MIN cycles.
- SW_RELEASE: masked bits drop in ascending index order, STAGGER_CYCLES apart.
  - Unmasked indices are skipped and consume no cycles.
  - On the last masked bit: return to RUN and increment seq_count.
- sw_reset_req outside RUN (POR_HOLD, RELEASE, SW_HOLD, SW_RELEASE) is ignored; it is not queued.
- Request arriving on the same cycle RUN is entered: ignored (RUN becomes visible the following cycle).
- reset during a software sequence: aborts it; full power-on sequence follows; seq_count is unchanged by the abort.
- Outputs are glitch-free: reset_o comes directly from flops.

Test Plan:
1. Defaults; reset=1 for 3 cycles, then 0 → reset_o:
   - 1111 in cycles 0-19;
   - 1110 at 20, 1100 at 24, 1000 at 28, 0000 at 32;
   - at 32: all_released=1, busy=0, seq_count=1.
2. In RUN, pulse sw_reset_req with mask=1010 at cycle T → reset_o:
   - 1010 at T+1..T+8;
   - 1000 at T+9, 0000 at T+13;
   - seq_count=2; bits 0 and 2 stay 0 throughout.
3. Pulse sw_reset_req with mask=0000 in RUN, and with mask=1111 at cycle 10 of POR_HOLD → no change in reset_o, busy, or seq_count versus scenario 1 timing.
4. Assert reset at cycle 26 of the power-on sequence (reset_o=1100) → reset_o=1111 next cycle; release restarts at cycle 20 after reset falls; seq_count unchanged until completion.
5. Second sw_reset_req (mask=0001) during SW_HOLD of scenario 2 → ignored; bit 0 stays 0; only one seq_count increment.
6. STAGGER_CYCLES=0, POR_CYCLES=5 → reset_o goes 1111→0000 in cycle 5 with all_released=1 the same cycle.
